// File: rtl/mbist_mem_cmp_if.sv
// Bundle of the MBIST command stream, SRAM pins and compare status for mbist_mem_cmp.
// The slave modport is the comparator's view; master is the driver/observer side.
interface mbist_mem_cmp_if #(
   parameter int AX_WIDTH  = 2,
   parameter int AY_WIDTH  = 2,
   parameter int D_WIDTH   = 2,
   parameter int CNT_WIDTH = 8
);
   logic                         i_en;
   logic                         i_clr;
   logic [1:0]                   i_op_cmd;
   logic [AX_WIDTH-1:0]          i_addr_x;
   logic [AY_WIDTH-1:0]          i_addr_y;
   logic [D_WIDTH-1:0]           i_data;
   logic [D_WIDTH-1:0]           i_mem_q;
   logic [AX_WIDTH+AY_WIDTH-1:0] o_mem_a;
   logic [D_WIDTH-1:0]           o_mem_d;
   logic                         o_mem_we;
   logic                         o_mem_re;
   logic                         o_cmp_valid;
   logic                         o_fail;
   logic [CNT_WIDTH-1:0]         o_fail_cnt;
   logic [AX_WIDTH+AY_WIDTH-1:0] o_fail_addr;
   logic [D_WIDTH-1:0]           o_fail_exp;
   logic [D_WIDTH-1:0]           o_fail_act;
   logic                         o_busy;

   modport slave (
      input  i_en, i_clr, i_op_cmd, i_addr_x, i_addr_y, i_data, i_mem_q,
      output o_mem_a, o_mem_d, o_mem_we, o_mem_re, o_cmp_valid, o_fail,
             o_fail_cnt, o_fail_addr, o_fail_exp, o_fail_act, o_busy
   );

   modport master (
      output i_en, i_clr, i_op_cmd, i_addr_x, i_addr_y, i_data, i_mem_q,
      input  o_mem_a, o_mem_d, o_mem_we, o_mem_re, o_cmp_valid, o_fail,
             o_fail_cnt, o_fail_addr, o_fail_exp, o_fail_act, o_busy
   );
endinterface

// File: rtl/mbist_mem_cmp.sv
// MBIST memory-side stage: registers commands onto SRAM pins, carries expected data
// through a read-latency-matched pipeline and keeps sticky first-fail status.
module mbist_mem_cmp #(
   parameter int AX_WIDTH  = 2,
   parameter int AY_WIDTH  = 2,
   parameter int D_WIDTH   = 2,
   parameter int RD_LAT    = 1,
   parameter int CNT_WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   mbist_mem_cmp_if.slave  bus
);
   localparam int A_WIDTH = AX_WIDTH + AY_WIDTH;
   localparam int DEPTH   = RD_LAT + 1;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic                            is_wr_s, is_rd_s, cmp_en_s, mism_s;
   logic [A_WIDTH-1:0]              in_addr_s;
   logic [A_WIDTH-1:0]              mem_a_q, mem_a_d;
   logic [D_WIDTH-1:0]              mem_d_q, mem_d_d;
   logic                            mem_we_q;
   logic [DEPTH-1:0]                pv_q;
   logic [DEPTH-1:0][A_WIDTH-1:0]   pa_q;
   logic [DEPTH-1:0][D_WIDTH-1:0]   pe_q;
   logic                            cmp_valid_q;
   logic                            fail_q, fail_d;
   logic [CNT_WIDTH-1:0]            cnt_q, cnt_d;
   logic [A_WIDTH-1:0]              fa_q, fa_d;
   logic [D_WIDTH-1:0]              fe_q, fe_d, fq_q, fq_d;

   assign in_addr_s = {bus.i_addr_x, bus.i_addr_y};
   assign is_wr_s   = bus.i_en && (bus.i_op_cmd == OP_WRITE);
   assign is_rd_s   = bus.i_en && (bus.i_op_cmd == OP_READ);
   // The oldest pipeline stage lines up with i_mem_q for its read.
   assign cmp_en_s  = pv_q[DEPTH-1];
   assign mism_s    = cmp_en_s && (bus.i_mem_q != pe_q[DEPTH-1]);

   // Issue stage next-state: address/data pins hold through idle cycles.
   always_comb begin
      mem_a_d = mem_a_q;
      mem_d_d = mem_d_q;
      if (is_wr_s || is_rd_s) begin
         mem_a_d = in_addr_s;
      end else begin
         mem_a_d = mem_a_q;
      end
      if (is_wr_s) begin
         mem_d_d = bus.i_data;
      end else begin
         mem_d_d = mem_d_q;
      end
   end

   // Fail status next-state: a mismatch in the clear cycle overrides the clear.
   always_comb begin
      fail_d = fail_q;
      cnt_d  = cnt_q;
      fa_d   = fa_q;
      fe_d   = fe_q;
      fq_d   = fq_q;
      if (bus.i_clr) begin
         fail_d = 1'b0;
         cnt_d  = {CNT_WIDTH{1'b0}};
         fa_d   = {A_WIDTH{1'b0}};
         fe_d   = {D_WIDTH{1'b0}};
         fq_d   = {D_WIDTH{1'b0}};
      end else begin
         fail_d = fail_q;
      end
      if (mism_s) begin
         fail_d = 1'b1;
         if (bus.i_clr) begin
            cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q;
         end
         if (bus.i_clr || !fail_q) begin
            fa_d = pa_q[DEPTH-1];
            fe_d = pe_q[DEPTH-1];
            fq_d = bus.i_mem_q;
         end else begin
            fa_d = fa_q;
         end
      end else begin
         cnt_d = cnt_d;
      end
   end

   // State registers with synchronous active-low reset; reset also flushes the pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_a_q     <= {A_WIDTH{1'b0}};
         mem_d_q     <= {D_WIDTH{1'b0}};
         mem_we_q    <= 1'b0;
         pv_q        <= {DEPTH{1'b0}};
         pa_q        <= '0;
         pe_q        <= '0;
         cmp_valid_q <= 1'b0;
         fail_q      <= 1'b0;
         cnt_q       <= {CNT_WIDTH{1'b0}};
         fa_q        <= {A_WIDTH{1'b0}};
         fe_q        <= {D_WIDTH{1'b0}};
         fq_q        <= {D_WIDTH{1'b0}};
      end else begin
         mem_a_q     <= mem_a_d;
         mem_d_q     <= mem_d_d;
         mem_we_q    <= is_wr_s;
         pv_q        <= {pv_q[DEPTH-2:0], is_rd_s};
         pa_q        <= {pa_q[DEPTH-2:0], in_addr_s};
         pe_q        <= {pe_q[DEPTH-2:0], bus.i_data};
         cmp_valid_q <= cmp_en_s;
         fail_q      <= fail_d;
         cnt_q       <= cnt_d;
         fa_q        <= fa_d;
         fe_q        <= fe_d;
         fq_q        <= fq_d;
      end
   end

   assign bus.o_mem_a     = mem_a_q;
   assign bus.o_mem_d     = mem_d_q;
   assign bus.o_mem_we    = mem_we_q;
   assign bus.o_mem_re    = pv_q[0];
   assign bus.o_cmp_valid = cmp_valid_q;
   assign bus.o_fail      = fail_q;
   assign bus.o_fail_cnt  = cnt_q;
   assign bus.o_fail_addr = fa_q;
   assign bus.o_fail_exp  = fe_q;
   assign bus.o_fail_act  = fq_q;
   assign bus.o_busy      = |pv_q;
endmodule
